// File: rtl/id_ex_reg_pkg.sv
// Shared decode constants for the ID/EX boundary.
// The ALU, the main decoder and the ID/EX pipeline register all use this package.
package id_ex_reg_pkg;

  localparam int unsigned CtrlW = 7;

  // Bit positions inside id_ctrl: {regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst}
  localparam int unsigned CtrlRegWrite = 6;
  localparam int unsigned CtrlMemToReg = 5;
  localparam int unsigned CtrlMemRead  = 4;
  localparam int unsigned CtrlMemWrite = 3;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlAluSrc   = 1;
  localparam int unsigned CtrlRegDst   = 0;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluNor = 4'b1100,
    AluXor = 4'b1101
  } alu_ctl_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctNor = 6'b100111;
  localparam logic [5:0] FunctXor = 6'b100110;

  // Everything the EX stage receives, held as one register.
  typedef struct packed {
    logic        valid;
    logic [5:0]  ctrl;
    logic [3:0]  alu_ctl;
    logic        illegal;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
  } ex_stage_t;

  // regdst is consumed in ID to pick the write register; EX only sees the upper six bits.
  function automatic logic [5:0] ex_ctrl_of(input logic [CtrlW-1:0] ctrl);
    return ctrl[CtrlRegWrite:CtrlAluSrc];
  endfunction

endpackage

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: ID-side inputs, EX-side registered outputs.
// The register block takes the slave view; the driver of the ID stage takes master.
interface id_ex_if #(
  parameter int unsigned CNT_W = 16
);

  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [6:0]       id_ctrl;
  logic [1:0]       id_aluop;
  logic [5:0]       id_funct;
  logic [31:0]      id_rs_data;
  logic [31:0]      id_rt_data;
  logic [31:0]      id_imm;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;

  logic             ex_valid;
  logic [5:0]       ex_ctrl;
  logic [3:0]       ex_alu_ctl;
  logic             ex_illegal;
  logic [31:0]      ex_rs_data;
  logic [31:0]      ex_rt_data;
  logic [31:0]      ex_imm;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_wreg;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_ctrl, id_aluop, id_funct,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl, ex_alu_ctl, ex_illegal, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_wreg, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_ctrl, id_aluop, id_funct,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl, ex_alu_ctl, ex_illegal, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_wreg, bubble_cnt
  );

endinterface

// File: rtl/alu_ctl_dec.sv
// Combinational ALU control decoder: main-decoder class plus funct field to ALU op.
// Unknown operations decode to AND with the illegal flag, flagged only for real instructions.
module alu_ctl_dec
  import id_ex_reg_pkg::*;
(
  input  logic       valid_i,
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       illegal_o
);

  logic undecodable;

  always_comb begin
    alu_ctl_o   = AluAnd;
    undecodable = 1'b0;
    unique case (aluop_i)
      AluOpAdd: alu_ctl_o = AluAdd;
      AluOpSub: alu_ctl_o = AluSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: alu_ctl_o = AluAdd;
          FunctSub: alu_ctl_o = AluSub;
          FunctAnd: alu_ctl_o = AluAnd;
          FunctOr:  alu_ctl_o = AluOr;
          FunctSlt: alu_ctl_o = AluSlt;
          FunctNor: alu_ctl_o = AluNor;
          FunctXor: alu_ctl_o = AluXor;
          default: begin
            alu_ctl_o   = AluAnd;
            undecodable = 1'b1;
          end
        endcase
      end
      AluOpRsvd: begin
        alu_ctl_o   = AluAnd;
        undecodable = 1'b1;
      end
      default: begin
        alu_ctl_o   = AluAnd;
        undecodable = 1'b1;
      end
    endcase
  end

  assign illegal_o = undecodable & valid_i;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with ALU-control decode ahead of the flops, stall/flush handling
// and a saturating count of bubbles inserted into the execute stage.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  logic [3:0] dec_alu_ctl;
  logic       dec_illegal;

  alu_ctl_dec u_alu_ctl_dec (
    .valid_i   (bus.id_valid),
    .aluop_i   (aluop_e'(bus.id_aluop)),
    .funct_i   (bus.id_funct),
    .alu_ctl_o (dec_alu_ctl),
    .illegal_o (dec_illegal)
  );

  ex_stage_t        stage_d, stage_q;
  ex_stage_t        stage_load;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_bubble;

  always_comb begin
    stage_load         = '0;
    stage_load.valid   = 1'b1;
    stage_load.ctrl    = ex_ctrl_of(bus.id_ctrl);
    stage_load.alu_ctl = dec_alu_ctl;
    stage_load.illegal = dec_illegal;
    stage_load.rs_data = bus.id_rs_data;
    stage_load.rt_data = bus.id_rt_data;
    stage_load.imm     = bus.id_imm;
    stage_load.rs      = bus.id_rs;
    stage_load.rt      = bus.id_rt;
    stage_load.wreg    = bus.id_ctrl[CtrlRegDst] ? bus.id_rd : bus.id_rt;
  end

  // flush beats stall; an empty decode slot becomes a bubble only when not stalled.
  assign load_bubble = bus.flush | (~bus.stall & ~bus.id_valid);

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (load_bubble) begin
      stage_d = '0;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (!bus.stall) begin
      stage_d = stage_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_valid   = stage_q.valid;
  assign bus.ex_ctrl    = stage_q.ctrl;
  assign bus.ex_alu_ctl = stage_q.alu_ctl;
  assign bus.ex_illegal = stage_q.illegal;
  assign bus.ex_rs_data = stage_q.rs_data;
  assign bus.ex_rt_data = stage_q.rt_data;
  assign bus.ex_imm     = stage_q.imm;
  assign bus.ex_rs      = stage_q.rs;
  assign bus.ex_rt      = stage_q.rt;
  assign bus.ex_wreg    = stage_q.wreg;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: a 16-bit-counter and a 4-bit-counter instance share the same stimulus,
// a behavioural model is compared every cycle, and literal expectations pin key scenarios.
module tb_id_ex_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.CNT_W(16)) bus ();
  id_ex_if #(.CNT_W(4))  bus4 ();

  id_ex_reg #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  id_ex_reg #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.stall      = bus.stall;
  assign bus4.flush      = bus.flush;
  assign bus4.id_valid   = bus.id_valid;
  assign bus4.id_ctrl    = bus.id_ctrl;
  assign bus4.id_aluop   = bus.id_aluop;
  assign bus4.id_funct   = bus.id_funct;
  assign bus4.id_rs_data = bus.id_rs_data;
  assign bus4.id_rt_data = bus.id_rt_data;
  assign bus4.id_imm     = bus.id_imm;
  assign bus4.id_rs      = bus.id_rs;
  assign bus4.id_rt      = bus.id_rt;
  assign bus4.id_rd      = bus.id_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 1'b0;
  logic        m_valid, m_illegal;
  logic [5:0]  m_ctrl;
  logic [3:0]  m_alu;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_wreg;
  int          m_cnt16, m_cnt4;

  function automatic void ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                  output logic [3:0] code, output logic bad);
    bad  = 1'b0;
    code = 4'b0000;
    if (op == 2'b00) code = 4'b0010;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) bad = 1'b1;
    else begin
      case (fn)
        6'b100000: code = 4'b0010;
        6'b100010: code = 4'b0110;
        6'b100100: code = 4'b0000;
        6'b100101: code = 4'b0001;
        6'b101010: code = 4'b0111;
        6'b100111: code = 4'b1100;
        6'b100110: code = 4'b1101;
        default:   bad  = 1'b1;
      endcase
    end
  endfunction

  task automatic m_clear();
    m_valid = 0; m_illegal = 0; m_ctrl = 0; m_alu = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wreg = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      m_cnt16 = 0;
      m_cnt4  = 0;
      m_init  = 1'b1;
    end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      m_clear();
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end else if (!bus.stall) begin
      logic [3:0] code;
      logic       bad;
      ref_alu(bus.id_aluop, bus.id_funct, code, bad);
      m_valid   = 1'b1;
      m_alu     = code;
      m_illegal = bad;
      m_ctrl    = bus.id_ctrl >> 1;
      m_rs_data = bus.id_rs_data;
      m_rt_data = bus.id_rt_data;
      m_imm     = bus.id_imm;
      m_rs      = bus.id_rs;
      m_rt      = bus.id_rt;
      m_wreg    = bus.id_ctrl[0] ? bus.id_rd : bus.id_rt;
    end
  end

  // compare on the falling edge, half a cycle away from the update
  always @(negedge clk) begin
    if (m_init) begin
      chk("ex_valid",   bus.ex_valid,   m_valid);
      chk("ex_ctrl",    bus.ex_ctrl,    m_ctrl);
      chk("ex_alu_ctl", bus.ex_alu_ctl, m_alu);
      chk("ex_illegal", bus.ex_illegal, m_illegal);
      chk("ex_rs_data", bus.ex_rs_data, m_rs_data);
      chk("ex_rt_data", bus.ex_rt_data, m_rt_data);
      chk("ex_imm",     bus.ex_imm,     m_imm);
      chk("ex_rs",      bus.ex_rs,      m_rs);
      chk("ex_rt",      bus.ex_rt,      m_rt);
      chk("ex_wreg",    bus.ex_wreg,    m_wreg);
      chk("bubble_cnt", bus.bubble_cnt, 64'(m_cnt16));
      chk("bubble_cnt4", bus4.bubble_cnt, 64'(m_cnt4));
      chk("w4_ex_valid", bus4.ex_valid, m_valid);
      chk("w4_ex_alu", bus4.ex_alu_ctl, m_alu);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] ctrl, input logic [1:0] op,
                       input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    bus.id_valid = v; bus.id_ctrl = ctrl; bus.id_aluop = op; bus.id_funct = fn;
    bus.id_rs_data = a; bus.id_rt_data = b; bus.id_imm = imm;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 6'b111111, 4'b0110, 1'b0};
    vecs[2]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[3]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[6]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[8]  = '{2'b10, 6'b100110, 4'b1101, 1'b0};
    vecs[9]  = '{2'b10, 6'b000011, 4'b0000, 1'b1};
    vecs[10] = '{2'b11, 6'b100000, 4'b0000, 1'b1};

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 7'h7f, 2'b10, 6'b100000, 32'hdead, 32'hbeef, 32'h1, 5'd1, 5'd2, 5'd3);
    tick();
    chk("reset_valid", bus.ex_valid, 1'b0);
    chk("reset_cnt", bus.bubble_cnt, 16'd0);
    chk("reset_rs_data", bus.ex_rs_data, 32'd0);

    // R-type slt, regdst=1, rd=9
    rst = 1'b0;
    drive(1'b1, 7'b1000001, 2'b10, 6'b101010, 32'd5, 32'd7, 32'h1234, 5'd1, 5'd3, 5'd9);
    tick();
    chk("slt_alu", bus.ex_alu_ctl, 4'b0111);
    chk("slt_wreg", bus.ex_wreg, 5'd9);
    chk("slt_valid", bus.ex_valid, 1'b1);
    chk("slt_rs_data", bus.ex_rs_data, 32'd5);
    chk("slt_ctrl", bus.ex_ctrl, 6'b100000);

    // three stalls while ID changes, including an empty slot
    bus.stall = 1'b1;
    drive(1'b1, 7'b0110010, 2'b00, 6'b0, 32'd11, 32'd12, 32'd13, 5'd4, 5'd5, 5'd6);
    tick();
    drive(1'b0, 7'h7f, 2'b11, 6'b0, 32'd21, 32'd22, 32'd23, 5'd7, 5'd8, 5'd10);
    tick();
    drive(1'b1, 7'b0001000, 2'b01, 6'b0, 32'd31, 32'd32, 32'd33, 5'd11, 5'd12, 5'd13);
    tick();
    chk("stall_alu", bus.ex_alu_ctl, 4'b0111);
    chk("stall_rs_data", bus.ex_rs_data, 32'd5);
    chk("stall_wreg", bus.ex_wreg, 5'd9);
    chk("stall_cnt", bus.bubble_cnt, 16'd0);

    // flush together with stall, regwrite asserted on input
    bus.flush = 1'b1;
    drive(1'b1, 7'b1000000, 2'b00, 6'b0, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3);
    tick();
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_ctrl", bus.ex_ctrl, 6'b000000);
    chk("flush_cnt", bus.bubble_cnt, 16'd1);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 7'b1000001, vecs[i].op, vecs[i].fn, 32'(i * 3), 32'(i * 5 + 1),
            32'hffff_fff0 + 32'(i), 5'(i), 5'(i + 1), 5'(i + 20));
      tick();
      chk("vec_alu", bus.ex_alu_ctl, vecs[i].code);
      chk("vec_illegal", bus.ex_illegal, vecs[i].ill);
    end

    // undecodable op in an empty slot: plain bubble, not illegal
    drive(1'b0, 7'b1000001, 2'b10, 6'b000011, 32'd9, 32'd9, 32'd9, 5'd9, 5'd9, 5'd9);
    tick();
    chk("inv_illegal", bus.ex_illegal, 1'b0);
    chk("inv_valid", bus.ex_valid, 1'b0);
    chk("inv_cnt", bus.bubble_cnt, 16'd2);

    // regdst=0 selects rt; zero register indices pass through
    drive(1'b1, 7'b1101010, 2'b00, 6'b0, 32'hcafe, 32'hf00d, 32'h8000_0000, 5'd0, 5'd0, 5'd17);
    tick();
    chk("rt_wreg", bus.ex_wreg, 5'd0);
    chk("rt_ctrl", bus.ex_ctrl, 6'b110101);
    drive(1'b1, 7'b1000000, 2'b01, 6'b0, 32'h1, 32'h2, 32'h3, 5'd0, 5'd14, 5'd17);
    tick();
    chk("rt_wreg2", bus.ex_wreg, 5'd14);

    // reset while stalled
    bus.stall = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_stall_valid", bus.ex_valid, 1'b0);
    chk("rst_stall_cnt", bus.bubble_cnt, 16'd0);
    chk("rst_stall_wreg", bus.ex_wreg, 5'd0);
    rst = 1'b0;
    bus.stall = 1'b0;

    bus.flush = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt4", bus4.bubble_cnt, 4'hf);
    chk("sat_cnt16", bus.bubble_cnt, 16'd17);
    bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    chk("final_cnt4", bus4.bubble_cnt, 4'h0);
    chk("final_valid", bus4.ex_valid, 1'b0);
    chk("final_cnt16", bus.bubble_cnt, 16'd0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
